// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: a free-running cycle counter that flags the last cycle
// of every bit period. Shared by the transmitter and the future receiver.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count;
  logic             terminal;

  assign terminal = (count == CNT_W'(CLKS_PER_BIT - 1));
  assign tick     = terminal & ~clear;

  // Count cycles within a bit, wrapping at terminal count; clear holds it at zero.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (terminal) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO while idle and enabled, and
// serialises each as start, data (LSB first), optional parity and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int   BIT_W   = $clog2(DATA_WIDTH + 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  uart_tx_state_t        state;
  uart_tx_state_t        state_next;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  parity_q;
  logic                  tx_q;
  logic                  tx_d;
  logic                  baud_clear;
  logic                  baud_tick;
  logic                  last_data_bit;
  logic                  last_stop_bit;

  assign last_data_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign last_stop_bit = (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign baud_clear    = (state == IDLE) || (state == LOAD);
  assign tx            = tx_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .Clk  (Clk),
    .Reset(Reset),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  // State register; reset abandons any frame in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing: each line phase advances on the baud tick.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fifo_rd_en) state_next = LOAD;
      LOAD:   state_next = START;
      START:  if (baud_tick) state_next = DATA;
      DATA: begin
        if (baud_tick && last_data_bit) begin
          state_next = HAS_PAR ? PARITY : STOP;
        end
      end
      PARITY: if (baud_tick) state_next = STOP;
      STOP:   if (baud_tick && last_stop_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: pop only from IDLE, and pre-compute the line level for the
  // upcoming state so the registered tx lines up with that state.
  always_comb begin
    fifo_rd_en = (state == IDLE) & tx_enable & ~fifo_empty & ~Reset;
    busy       = (state != IDLE);
    case (state_next)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_next[0];
      PARITY:  tx_d = parity_q;
      default: tx_d = 1'b1;
    endcase
  end

  // Shift register contents for the next cycle: load on LOAD, shift at the end of each data bit.
  always_comb begin
    shift_next = shift_q;
    if (state == LOAD) begin
      shift_next = fifo_data;
    end else if ((state == DATA) && baud_tick) begin
      shift_next = shift_q >> 1;
    end
  end

  // Datapath registers: shifter, bit/stop counter, parity and the line driver.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      shift_q <= shift_next;
      tx_q    <= tx_d;
      case (state)
        LOAD: begin
          bit_cnt  <= '0;
          parity_q <= (^fifo_data) ^ ODD_BIT;
        end
        DATA: begin
          if (baud_tick) begin
            bit_cnt <= last_data_bit ? '0 : bit_cnt + BIT_W'(1);
          end
        end
        STOP: begin
          if (baud_tick) begin
            bit_cnt <= last_stop_bit ? '0 : bit_cnt + BIT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
